// File: rtl/ysyx_23060332_pkg.sv
// Shared decode definitions for the ysyx_23060332 core.
// Holds opcode/funct constants, the ALU / branch / memory-size encodings,
// the EBREAK/ECALL words, the NOP control bundle, and a funct3-to-ALU helper.
package ysyx_23060332_pkg;

    localparam int unsigned ALU_OP_W = 5;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD      = 5'd0,
        ALU_SUB      = 5'd1,
        ALU_SLL      = 5'd2,
        ALU_SLT      = 5'd3,
        ALU_SLTU     = 5'd4,
        ALU_XOR      = 5'd5,
        ALU_SRL      = 5'd6,
        ALU_SRA      = 5'd7,
        ALU_OR       = 5'd8,
        ALU_AND      = 5'd9,
        ALU_COPY_OP1 = 5'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_JAL  = 3'd7
    } br_type_t;

    // Memory access size, mem_op[1:0]
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic       reg_wen;
        alu_op_t    alu_op;
        logic [3:0] mem_op;
        logic       mem_unsigned;
        br_type_t   br_type;
        logic       word_op;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{
        reg_wen:      1'b0,
        alu_op:       ALU_ADD,
        mem_op:       4'b0000,
        mem_unsigned: 1'b0,
        br_type:      BR_NONE,
        word_op:      1'b0
    };

    // alt selects SUB for funct3=000 and SRA for funct3=101.
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ysyx_23060332_imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediates.
// Ports: inst[31:7] (opcode bits are not needed), imm_i/s/b/u/j (XLEN wide).
module ysyx_23060332_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    // Size casts of signed values sign-extend to XLEN.
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

endmodule

// File: rtl/ysyx_23060332_idu_stage.sv
// Instruction decode stage between IFU and EXU.
// Decodes RV32I (plus RV64I W/LD/SD/LWU when XLEN=64) into ALU operands,
// jump operands and control fields, held in a single registered output slot.
// Ports: clk/rst (sync, active high), flush; IFU side in_valid/in_ready,
// inst_i, pc_i; regfile raddr1/raddr2 -> rdata1_i/rdata2_i (same cycle);
// EXU side out_valid/out_ready and the decoded bundle; status illegal/halted.
module ysyx_23060332_idu_stage
    import ysyx_23060332_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int ALUOP_W         = 5,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    pc_i,
    output logic [4:0]         raddr1,
    output logic [4:0]         raddr2,
    input  logic [XLEN-1:0]    rdata1_i,
    input  logic [XLEN-1:0]    rdata2_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    op1,
    output logic [XLEN-1:0]    op2,
    output logic [XLEN-1:0]    op1_jump,
    output logic [XLEN-1:0]    op2_jump,
    output logic [XLEN-1:0]    store_data,
    output logic               reg_wen,
    output logic [4:0]         waddr,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         mem_op,
    output logic               mem_unsigned,
    output logic [2:0]         br_type,
    output logic               word_op,
    output logic [XLEN-1:0]    pc_o,
    output logic [31:0]        inst_o,
    output logic               illegal,
    output logic               halted
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("ysyx_23060332_idu_stage: XLEN must be 32 or 64");
    end
    if (ALUOP_W != ALU_OP_W) begin : g_bad_aluop_w
        $error("ysyx_23060332_idu_stage: ALUOP_W must match the package");
    end

    localparam bit IS64 = (XLEN == 64);

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    ysyx_23060332_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst  (inst_i[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [5:0] shamt;
    logic [6:0] shift_hi;
    logic [6:0] shift_sra;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign rd     = inst_i[11:7];
    // Shift-immediate fields: on RV64 bit 25 belongs to shamt.
    assign shamt     = IS64 ? inst_i[25:20] : {1'b0, inst_i[24:20]};
    assign shift_hi  = IS64 ? {1'b0, inst_i[31:26]} : inst_i[31:25];
    assign shift_sra = IS64 ? 7'b0010000 : F7_ALT;

    ctrl_t           d_ctrl;
    logic [XLEN-1:0] d_op1, d_op2, d_opj1, d_opj2, d_store;
    logic            d_illegal;
    logic            d_rs1_used, d_rs2_used;

    always_comb begin
        d_ctrl     = NOP_CTRL;
        d_op1      = '0;
        d_op2      = '0;
        d_opj1     = '0;
        d_opj2     = '0;
        d_store    = '0;
        d_illegal  = 1'b0;
        d_rs1_used = 1'b0;
        d_rs2_used = 1'b0;

        case (opcode)
            OPC_LUI: begin
                d_ctrl.reg_wen = 1'b1;
                d_ctrl.alu_op  = ALU_COPY_OP1;
                d_op1          = imm_u;
            end
            OPC_AUIPC: begin
                d_ctrl.reg_wen = 1'b1;
                d_op1          = pc_i;
                d_op2          = imm_u;
            end
            OPC_JAL: begin
                d_ctrl.reg_wen = 1'b1;
                d_ctrl.br_type = BR_JAL;
                d_op1          = pc_i;
                d_op2          = XLEN'(4);
                d_opj1         = pc_i;
                d_opj2         = imm_j;
            end
            OPC_JALR: begin
                d_rs1_used     = 1'b1;
                d_illegal      = (f3 != 3'b000);
                d_ctrl.reg_wen = 1'b1;
                d_ctrl.br_type = BR_JAL;
                d_op1          = pc_i;
                d_op2          = XLEN'(4);
                d_opj1         = rdata1_i;
                d_opj2         = imm_i;
            end
            OPC_BRANCH: begin
                d_rs1_used    = 1'b1;
                d_rs2_used    = 1'b1;
                d_ctrl.alu_op = ALU_SUB;
                d_op1         = rdata1_i;
                d_op2         = rdata2_i;
                d_opj1        = pc_i;
                d_opj2        = imm_b;
                case (f3)
                    F3_BEQ:  d_ctrl.br_type = BR_BEQ;
                    F3_BNE:  d_ctrl.br_type = BR_BNE;
                    F3_BLT:  d_ctrl.br_type = BR_BLT;
                    F3_BGE:  d_ctrl.br_type = BR_BGE;
                    F3_BLTU: d_ctrl.br_type = BR_BLTU;
                    F3_BGEU: d_ctrl.br_type = BR_BGEU;
                    default: d_illegal      = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_rs1_used          = 1'b1;
                d_ctrl.reg_wen      = 1'b1;
                d_ctrl.mem_op       = {1'b1, 1'b0, f3[1:0]};
                d_ctrl.mem_unsigned = f3[2];
                d_op1               = rdata1_i;
                d_op2               = imm_i;
                case (f3)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ;
                    3'd3, 3'd6: d_illegal = !IS64;
                    default:    d_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_rs1_used    = 1'b1;
                d_rs2_used    = 1'b1;
                d_ctrl.mem_op = {1'b0, 1'b1, f3[1:0]};
                d_op1         = rdata1_i;
                d_op2         = imm_s;
                d_store       = rdata2_i;
                case (f3)
                    3'd0, 3'd1, 3'd2: ;
                    3'd3:    d_illegal = !IS64;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                d_rs1_used     = 1'b1;
                d_ctrl.reg_wen = 1'b1;
                d_ctrl.alu_op  = alu_from_f3(f3, 1'b0);
                d_op1          = rdata1_i;
                d_op2          = imm_i;
                if (f3 == F3_SLL) begin
                    d_op2     = XLEN'(shamt);
                    d_illegal = (shift_hi != 7'd0);
                end else if (f3 == F3_SR) begin
                    d_op2         = XLEN'(shamt);
                    d_ctrl.alu_op = alu_from_f3(f3, inst_i[30]);
                    d_illegal     = (shift_hi != 7'd0) && (shift_hi != shift_sra);
                end
            end
            OPC_OP: begin
                d_rs1_used     = 1'b1;
                d_rs2_used     = 1'b1;
                d_ctrl.reg_wen = 1'b1;
                d_ctrl.alu_op  = alu_from_f3(f3, f7 == F7_ALT);
                d_op1          = rdata1_i;
                d_op2          = rdata2_i;
                d_illegal      = !((f7 == F7_BASE) ||
                                   (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
            end
            OPC_OP_IMM_32: begin
                d_rs1_used     = 1'b1;
                d_ctrl.reg_wen = 1'b1;
                d_ctrl.word_op = 1'b1;
                d_ctrl.alu_op  = alu_from_f3(f3, inst_i[30]);
                d_op1          = rdata1_i;
                d_op2          = imm_i;
                case (f3)
                    F3_ADD: d_illegal = !IS64;
                    F3_SLL: begin
                        d_op2     = XLEN'(inst_i[24:20]);
                        d_illegal = !IS64 || (f7 != F7_BASE);
                    end
                    F3_SR: begin
                        d_op2     = XLEN'(inst_i[24:20]);
                        d_illegal = !IS64 || !(f7 == F7_BASE || f7 == F7_ALT);
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                d_rs1_used     = 1'b1;
                d_rs2_used     = 1'b1;
                d_ctrl.reg_wen = 1'b1;
                d_ctrl.word_op = 1'b1;
                d_ctrl.alu_op  = alu_from_f3(f3, f7 == F7_ALT);
                d_op1          = rdata1_i;
                d_op2          = rdata2_i;
                d_illegal      = !IS64 ||
                                 !((f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_SLL || f3 == F3_SR)) ||
                                   (f7 == F7_ALT  && (f3 == F3_ADD || f3 == F3_SR)));
            end
            OPC_MISC_MEM: d_illegal = (f3 != 3'b000);
            OPC_SYSTEM:   d_illegal = !(inst_i == INST_ECALL || inst_i == INST_EBREAK);
            default:      d_illegal = 1'b1;
        endcase

        // Illegal words still flow downstream, but as a side-effect-free bundle.
        if (d_illegal) begin
            d_ctrl = NOP_CTRL;
        end
        if (rd == 5'd0) begin
            d_ctrl.reg_wen = 1'b0;
        end
    end

    assign raddr1 = d_rs1_used ? inst_i[19:15] : 5'd0;
    assign raddr2 = d_rs2_used ? inst_i[24:20] : 5'd0;

    state_t state, state_next;
    logic   capture;
    logic   halt_req;

    assign in_ready = (state == ST_RUN) && !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;
    assign halt_req = (inst_i == INST_EBREAK) || (HALT_ON_ILLEGAL && d_illegal);
    assign halted   = (state == ST_HALT);

    always_comb begin
        state_next = state;
        if (state == ST_RUN && capture && halt_req) begin
            state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    ctrl_t ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            ctrl_q     <= NOP_CTRL;
            op1        <= '0;
            op2        <= '0;
            op1_jump   <= '0;
            op2_jump   <= '0;
            store_data <= '0;
            waddr      <= '0;
            pc_o       <= '0;
            inst_o     <= '0;
            illegal    <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid  <= 1'b1;
                ctrl_q     <= d_ctrl;
                op1        <= d_op1;
                op2        <= d_op2;
                op1_jump   <= d_opj1;
                op2_jump   <= d_opj2;
                store_data <= d_store;
                waddr      <= rd;
                pc_o       <= pc_i;
                inst_o     <= inst_i;
                if (d_illegal) begin
                    illegal <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign reg_wen      = ctrl_q.reg_wen;
    assign alu_op       = ALUOP_W'(ctrl_q.alu_op);
    assign mem_op       = ctrl_q.mem_op;
    assign mem_unsigned = ctrl_q.mem_unsigned;
    assign br_type      = ctrl_q.br_type;
    assign word_op      = ctrl_q.word_op;

endmodule

// File: tb/tb_ysyx_23060332_idu_stage.sv
module tb_ysyx_23060332_idu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1_i, rdata2_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1, op2, op1_jump, op2_jump, store_data, pc_o;
    logic        reg_wen;
    logic [4:0]  waddr;
    logic [4:0]  alu_op;
    logic [3:0]  mem_op;
    logic        mem_unsigned;
    logic [2:0]  br_type;
    logic        word_op;
    logic [31:0] inst_o;
    logic        illegal, halted;

    // 64-bit instance
    logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64;
    logic [31:0] inst64, inst_o64;
    logic [63:0] pc64, rdata1_64, rdata2_64;
    logic [4:0]  raddr1_64, raddr2_64, waddr64, alu_op64;
    logic [63:0] op1_64, op2_64, opj1_64, opj2_64, store64, pc_o64;
    logic        reg_wen64, mem_uns64, word_op64, illegal64, halted64;
    logic [3:0]  mem_op64;
    logic [2:0]  br_type64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060332_idu_stage #(.XLEN(32), .ALUOP_W(5), .HALT_ON_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .pc_i(pc_i), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump),
        .store_data(store_data), .reg_wen(reg_wen), .waddr(waddr), .alu_op(alu_op),
        .mem_op(mem_op), .mem_unsigned(mem_unsigned), .br_type(br_type), .word_op(word_op),
        .pc_o(pc_o), .inst_o(inst_o), .illegal(illegal), .halted(halted)
    );

    ysyx_23060332_idu_stage #(.XLEN(64), .ALUOP_W(5), .HALT_ON_ILLEGAL(1'b1)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .inst_i(inst64), .pc_i(pc64), .raddr1(raddr1_64), .raddr2(raddr2_64),
        .rdata1_i(rdata1_64), .rdata2_i(rdata2_64), .out_valid(out_valid64), .out_ready(out_ready64),
        .op1(op1_64), .op2(op2_64), .op1_jump(opj1_64), .op2_jump(opj2_64),
        .store_data(store64), .reg_wen(reg_wen64), .waddr(waddr64), .alu_op(alu_op64),
        .mem_op(mem_op64), .mem_unsigned(mem_uns64), .br_type(br_type64), .word_op(word_op64),
        .pc_o(pc_o64), .inst_o(inst_o64), .illegal(illegal64), .halted(halted64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        go();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst_i = '0; pc_i = '0;
        rdata1_i = '0; rdata2_i = '0; out_ready = 1'b1;
        flush64 = 1'b0; in_valid64 = 1'b0; inst64 = '0; pc64 = '0;
        rdata1_64 = '0; rdata2_64 = '0; out_ready64 = 1'b1;
        go(); go();
        check("rst_out_valid", out_valid, 0);
        check("rst_op1", op1, 0);
        check("rst_inst_o", inst_o, 0);
        check("rst_illegal", illegal, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // addi x1,x0,5
        in_valid = 1'b1; inst_i = 32'h0050_0093; pc_i = 32'h8000_0000; rdata1_i = 32'h0;
        #1 check("addi_raddr1", raddr1, 0);
        check("addi_raddr2", raddr2, 0);
        go();
        check("addi_valid", out_valid, 1);
        check("addi_op1", op1, 0);
        check("addi_op2", op2, 5);
        check("addi_alu", alu_op, 0);
        check("addi_wen", reg_wen, 1);
        check("addi_waddr", waddr, 1);
        check("addi_pc", pc_o, 32'h8000_0000);

        // sw x2,4(x1)
        inst_i = 32'h0020_a223; rdata1_i = 32'h100; rdata2_i = 32'hABCD;
        #1 check("sw_raddr1", raddr1, 1);
        check("sw_raddr2", raddr2, 2);
        go();
        check("sw_op1", op1, 32'h100);
        check("sw_op2", op2, 4);
        check("sw_store", store_data, 32'hABCD);
        check("sw_mem_op", mem_op, 4'b0110);
        check("sw_wen", reg_wen, 0);

        // beq x0,x0,-4
        inst_i = 32'hfe00_0ee3; pc_i = 32'h8000_0010;
        go();
        check("beq_br", br_type, 1);
        check("beq_opj1", op1_jump, 32'h8000_0010);
        check("beq_opj2", op2_jump, 32'hFFFF_FFFC);
        check("beq_wen", reg_wen, 0);

        // jal x1,8
        inst_i = 32'h0080_00ef; pc_i = 32'h8000_0020;
        #1 check("jal_raddr1", raddr1, 0);
        go();
        check("jal_br", br_type, 7);
        check("jal_op1", op1, 32'h8000_0020);
        check("jal_op2", op2, 4);
        check("jal_opj2", op2_jump, 8);
        check("jal_wen", reg_wen, 1);

        // lui x1,0x12345
        inst_i = 32'h1234_50b7;
        go();
        check("lui_op1", op1, 32'h1234_5000);
        check("lui_op2", op2, 0);
        check("lui_alu", alu_op, 10);

        // srai x3,x1,4
        inst_i = 32'h4040_d193; rdata1_i = 32'h8000_0000;
        go();
        check("srai_op2", op2, 4);
        check("srai_alu", alu_op, 7);
        check("srai_waddr", waddr, 3);
        check("srai_illegal", illegal, 0);

        // Backpressure: hold addi x1,x0,3 for three cycles
        inst_i = 32'h0030_0093; rdata1_i = 32'h0;
        go();
        inst_i = 32'h0070_0113; out_ready = 1'b0;
        #1 check("bp_in_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            go();
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_op2", op2, 3);
            check("bp_inst_o", inst_o, 32'h0030_0093);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        go();
        check("bp_next_op2", op2, 7);
        check("bp_next_inst", inst_o, 32'h0070_0113);

        // Flush
        flush = 1'b1; inst_i = 32'h0090_0093;
        #1 check("flush_in_ready", in_ready, 0);
        go();
        check("flush_valid", out_valid, 0);
        check("flush_no_capture", inst_o, 32'h0070_0113);
        flush = 1'b0; in_valid = 1'b0;

        // Reset while a bundle is held
        in_valid = 1'b1; inst_i = 32'h0030_0093;
        go();
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        go();
        check("midrst_valid", out_valid, 0);
        check("midrst_op2", op2, 0);
        check("midrst_inst", inst_o, 0);
        rst = 1'b0; out_ready = 1'b1;

        // EBREAK halts; following instruction is refused
        in_valid = 1'b1; inst_i = 32'h0010_0073;
        go();
        check("ebreak_valid", out_valid, 1);
        check("ebreak_wen", reg_wen, 0);
        check("ebreak_br", br_type, 0);
        check("ebreak_halted", halted, 1);
        check("ebreak_in_ready", in_ready, 0);
        check("ebreak_illegal", illegal, 0);
        inst_i = 32'h0050_0093;
        go();
        check("halt_drained", out_valid, 0);
        check("halt_inst_o", inst_o, 32'h0010_0073);
        check("halt_in_ready", in_ready, 0);
        in_valid = 1'b0;
        do_reset();
        check("halt_rst_halted", halted, 0);
        check("halt_rst_ready", in_ready, 1);

        // ECALL does not halt
        in_valid = 1'b1; inst_i = 32'h0000_0073;
        go();
        check("ecall_halted", halted, 0);
        check("ecall_wen", reg_wen, 0);
        in_valid = 1'b0;

        // All-ones word is illegal
        in_valid = 1'b1; inst_i = 32'hFFFF_FFFF;
        go();
        check("ill_ff_illegal", illegal, 1);
        check("ill_ff_wen", reg_wen, 0);
        check("ill_ff_mem", mem_op, 0);
        check("ill_ff_halted", halted, 1);
        in_valid = 1'b0;
        do_reset();
        check("ill_rst_illegal", illegal, 0);

        // addw x5,x1,x2 is illegal on RV32
        in_valid = 1'b1; inst_i = 32'h0020_82BB;
        go();
        check("addw32_illegal", illegal, 1);
        check("addw32_wen", reg_wen, 0);
        check("addw32_halted", halted, 1);
        in_valid = 1'b0;
        do_reset();

        // slli with inst[25]=1 is illegal on RV32
        in_valid = 1'b1; inst_i = 32'h0210_9093;
        go();
        check("slli33_32_illegal", illegal, 1);
        in_valid = 1'b0;
        do_reset();

        // RV64 instance
        in_valid64 = 1'b1; inst64 = 32'h0020_82BB; rdata1_64 = 64'h1; rdata2_64 = 64'h2;
        go();
        check("addw64_illegal", illegal64, 0);
        check("addw64_word", word_op64, 1);
        check("addw64_wen", reg_wen64, 1);
        check("addw64_waddr", waddr64, 5);
        check("addw64_op2", op2_64, 2);
        inst64 = 32'h8000_00b7;
        go();
        check("lui64_op1", op1_64, 64'hFFFF_FFFF_8000_0000);
        check("lui64_word", word_op64, 0);
        inst64 = 32'h0210_9093;
        go();
        check("slli64_op2", op2_64, 33);
        check("slli64_illegal", illegal64, 0);
        check("slli64_halted", halted64, 0);
        in_valid64 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_idu_stage.md
Name: ysyx_23060332_idu_stage

Overview:
Pipelined, parametrised instruction decode stage that sits between IFU and EXU. It decodes the full RV32I base set, plus the RV64I W/LD/SD/LWU extensions when XLEN=64, into operands and control fields. Results are held in a registered output slot with valid/ready handshakes on both sides. Illegal-instruction and EBREAK conditions are reported as status outputs and stall the stage, rather than being raised as simulation-only callbacks.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal.
ALUOP_W, 5, width of the alu_op encoding; must match the package.
HALT_ON_ILLEGAL, 1, when 1 an illegal instruction halts the stage exactly as EBREAK does.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard the held and incoming instruction (redirect from EXU)
in_valid  in  1  IFU presents inst_i/pc_i
in_ready  out  1  stage can accept this cycle
inst_i  in  32  instruction word
pc_i  in  XLEN  instruction address
raddr1  out  5  regfile read port 1 (combinational from inst_i)
raddr2  out  5  regfile read port 2
rdata1_i  in  XLEN  regfile data 1 (same-cycle read)
rdata2_i  in  XLEN  regfile data 2
out_valid  out  1  decoded bundle valid to EXU
out_ready  in  1  EXU accepts
op1, op2  out  XLEN  ALU operands
op1_jump, op2_jump  out  XLEN  branch/jump target operands (target = op1_jump+op2_jump)
store_data  out  XLEN  rs2 value for stores
reg_wen  out  1  writeback enable (forced 0 when rd=x0)
waddr  out  5  writeback register
alu_op  out  ALUOP_W  ALU function
mem_op  out  4  {is_load, is_store, size[1:0]}; mem_unsigned is a separate signal
mem_unsigned  out  1  zero-extend load
br_type  out  3  NONE/BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL (JALR shares JAL with op1_jump=rs1)
word_op  out  1  RV64 *W result: sign-extend low 32 bits
pc_o  out  XLEN  registered PC
inst_o  out  32  registered instruction
illegal  out  1  sticky; an illegal instruction was decoded
halted  out  1  stage is in HALT

Behaviour:
- Reset: out_valid=0; every payload output=0; illegal=0; halted=0; state=RUN.
- Handshake: in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
- Capture: when in_valid && in_ready, the decoded bundle is registered on the next clk edge and out_valid=1. Latency is 1 cycle, and throughput is 1 per cycle under continuous out_ready.
- Hold: when out_valid && !out_ready, all outputs stay stable and in_ready=0.
- Flush: out_valid clears next cycle and nothing is captured that cycle. Flush does not exit HALT.
- raddr1/raddr2 are driven combinationally from inst_i. They are 0 for formats that do not read the register (U/J for both; I-type for raddr2).
- Immediates: I/S/B/U/J are sign-extended to XLEN. U-type is imm<<12, sign-extended for XLEN=64.
- Operand mapping:
  - OP-IMM: op1=rs1, op2=immI.
  - OP: op1=rs1, op2=rs2.
  - LOAD/STORE: op1=rs1, op2=immI/immS.
  - LUI: op1=immU, op2=0.
  - AUIPC: op1=pc, op2=immU.
  - JAL/JALR: op1=pc, op2=4; jump operands are (pc, immJ) for JAL and (rs1, immI) for JALR. The EXU clears bit 0 of the JALR target.
  - Branch: op1=rs1, op2=rs2, jump operands=(pc, immB).
- Shift immediates: shamt is inst[25:20] for XLEN=64 and inst[24:20] for XLEN=32. For XLEN=32, inst[25]=1 is illegal.
- word_op is set for OP-IMM-32 and OP-32 only when XLEN=64. Those opcodes are illegal when XLEN=32.
- Illegal instruction: any unlisted opcode/funct3/funct7 combination, or a zero instruction word.
  - It is still captured with reg_wen=0, mem_op=0, br_type=NONE.
  - illegal=1 (sticky until rst).
  - If HALT_ON_ILLEGAL, state goes to HALT.
- EBREAK (0x00100073): captured as a NOP bundle, then state goes to HALT.
  - ECALL and FENCE decode as NOP bundles and do not halt.
- FSM:
  - RUN → HALT on capture of EBREAK (or of an illegal instruction when HALT_ON_ILLEGAL).
  - HALT: in_ready=0, halted=1. The last bundle still drains through out_ready.
  - HALT → RUN only on rst.
- Reset mid-handshake: the held bundle is dropped; no partial output.

Decomposition:
- Package ysyx_23060332_pkg holds:
  - the opcode constants;
  - the funct3/funct7 constants;
  - the alu_op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, COPY_OP1);
  - the br_type and mem size encodings;
  - INST_EBREAK;
  - the NOP bundle constant.
- One combinational sub-module, ysyx_23060332_imm_gen (inst, XLEN → immI/S/B/U/J). The registered stage and FSM live in the top module.

Test Plan:
- XLEN=32, send 0x00500093 (addi x1,x0,5) with rdata1_i=0 and out_ready=1. Next cycle: out_valid=1, op1=0, op2=5, alu_op=ADD, reg_wen=1, waddr=1, raddr1=0.
- Send 0x0020a223 (sw x2,4(x1)) with rdata1_i=0x100, rdata2_i=0xABCD. Response: op1=0x100, op2=4, store_data=0xABCD, mem_op store/word, reg_wen=0.
- Send 0xfe000ee3 (beq x0,x0,-4) at pc_i=0x80000010. Response: br_type=BEQ, op1_jump=0x80000010, op2_jump=0xFFFFFFFC.
- Backpressure: hold out_ready=0 for 3 cycles after one capture. Required: in_ready=0 and outputs stable throughout; on out_ready=1 the next instruction is captured in the same cycle.
- Send 0x00100073 (ebreak), then more instructions. Required: one NOP bundle, halted=1 next cycle, in_ready stays 0; rst clears both.
- Send 0xFFFFFFFF, then separately 0x0000003B (addw) with XLEN=32. Each gives illegal=1, reg_wen=0; halted follows HALT_ON_ILLEGAL. With XLEN=64, addw decodes legally with word_op=1.
